// File: rtl/histoframe_evt_addr_gen.sv
// histoframe_evt_addr_gen: turns (x,y,pol) events into histogram-frame addresses base + y*width + x
// using an external pipelined multiplier, with bounds-check drop counting and output backpressure.
module histoframe_evt_addr_gen #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_x,
  input  logic [15:0] s_y,
  input  logic        s_pol,
  input  logic [15:0] cfg_width,
  input  logic [15:0] cfg_height,
  input  logic [31:0] cfg_base,
  output logic        mul_ce,
  output logic [15:0] mul_din0,
  output logic [15:0] mul_din1,
  input  logic [31:0] mul_dout,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  output logic        m_pol,
  output logic [15:0] drop_cnt,
  output logic        busy
);
  logic               stall, acc, inb;
  logic [MUL_LAT-1:0] vld_q, vld_d, pol_q;
  logic [15:0]        x_q [MUL_LAT];
  logic               m_valid_q, m_pol_q;
  logic [31:0]        m_addr_q;
  logic [15:0]        drop_q, drop_d;
  assign stall    = m_valid_q & ~m_ready;
  assign mul_ce   = ~stall;
  assign s_ready  = ~stall;
  assign mul_din0 = s_y;
  assign mul_din1 = cfg_width;
  assign acc      = s_valid & s_ready;
  assign inb      = (s_x < cfg_width) & (s_y < cfg_height);
  assign drop_d   = (acc & ~inb & ~&drop_q) ? drop_q + 16'd1 : drop_q;
  assign m_valid  = m_valid_q;
  assign m_addr   = m_addr_q;
  assign m_pol    = m_pol_q;
  assign drop_cnt = drop_q;
  assign busy     = |vld_q | m_valid_q;
  // out-of-bounds events enter the sideband as bubbles so the multiplier result is simply ignored
  always_comb begin
    vld_d = vld_q;
    vld_d[0] = acc & inb;
    for (int i = 1; i < MUL_LAT; i++) vld_d[i] = vld_q[i-1];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q     <= '0;
      m_valid_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      drop_q <= drop_d;
      if (mul_ce) begin
        vld_q     <= vld_d;
        m_valid_q <= vld_q[MUL_LAT-1];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (mul_ce) begin
      x_q[0]   <= s_x;
      pol_q[0] <= s_pol;
      for (int i = 1; i < MUL_LAT; i++) begin
        x_q[i]   <= x_q[i-1];
        pol_q[i] <= pol_q[i-1];
      end
      m_addr_q <= cfg_base + mul_dout + {16'd0, x_q[MUL_LAT-1]};
      m_pol_q  <= pol_q[MUL_LAT-1];
    end
  end
endmodule
